// File: rtl/key_word_if.sv
// Word-stream handshake bus between the key material source and the key word assembler.
// With KEY_PARITY_EN defined the bus also carries word_parity, an even parity bit over word_data.
interface key_word_if #(
    parameter int WORD_W = 32
) ();
    logic              word_valid;
    logic [WORD_W-1:0] word_data;
    logic              word_last;
    logic              word_ready;
`ifdef KEY_PARITY_EN
    logic              word_parity;
`endif

    modport master (
`ifdef KEY_PARITY_EN
        output word_parity,
`endif
        output word_valid, word_data, word_last,
        input  word_ready
    );

    modport slave (
`ifdef KEY_PARITY_EN
        input  word_parity,
`endif
        input  word_valid, word_data, word_last,
        output word_ready
    );
endinterface

// File: rtl/key_word_assembler.sv
// Assembles NUM_WORDS words MSB-first into one key and pulses key_load for one cycle, then zeroizes.
// Optional macro KEY_PARITY_EN adds an even-parity check on every accepted word (err_code 4).
module key_word_assembler #(
    parameter int WORD_W      = 32,
    parameter int NUM_WORDS   = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    key_word_if.slave                   kw,
    input  logic                        abort,
    output logic [WORD_W*NUM_WORDS-1:0] key_out,
    output logic                        key_load,
    output logic                        busy,
    output logic [2:0]                  err_code
);
    localparam int KEY_W = WORD_W * NUM_WORDS;
    localparam int CNT_W = $clog2(NUM_WORDS + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_FRAME = 3'd1;
    localparam logic [2:0] ERR_TMO   = 3'd2;
    localparam logic [2:0] ERR_ABORT = 3'd3;
`ifdef KEY_PARITY_EN
    localparam logic [2:0] ERR_PARITY = 3'd4;
`endif

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_PRESENT, S_ZEROIZE} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [TMO_W-1:0]   tmo_reg, tmo_next;
    logic [2:0]         err_reg, err_next;
    logic               wr_en, clr_en;
    logic               ready_int;
    logic               accept;
    logic               parity_bad;
    logic [KEY_W-1:0]   key_word;

    assign accept = kw.word_valid && ready_int;

`ifdef KEY_PARITY_EN
    assign parity_bad = ((^kw.word_data) != kw.word_parity);
`else
    assign parity_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            tmo_reg   <= '0;
            err_reg   <= ERR_NONE;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            tmo_reg   <= tmo_next;
            err_reg   <= err_next;
        end
    end

    // cnt_reg is the write slot while collecting and the wipe slot while zeroizing.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        tmo_next   = tmo_reg;
        err_next   = err_reg;
        wr_en      = 1'b0;
        clr_en     = 1'b0;
        case (state_reg)
            S_IDLE, S_COLLECT: begin
                if (state_reg == S_COLLECT && abort) begin
                    err_next   = ERR_ABORT;
                    cnt_next   = '0;
                    state_next = S_ZEROIZE;
                end else if (accept) begin
                    wr_en    = 1'b1;
                    tmo_next = '0;
                    if (state_reg == S_IDLE)
                        err_next = ERR_NONE;
                    if (parity_bad) begin
`ifdef KEY_PARITY_EN
                        err_next = ERR_PARITY;
`endif
                        cnt_next   = '0;
                        state_next = S_ZEROIZE;
                    end else if (cnt_reg == LAST_IDX && kw.word_last) begin
                        state_next = S_PRESENT;
                    end else if (cnt_reg == LAST_IDX || kw.word_last) begin
                        err_next   = ERR_FRAME;
                        cnt_next   = '0;
                        state_next = S_ZEROIZE;
                    end else begin
                        cnt_next   = cnt_reg + CNT_W'(1);
                        state_next = S_COLLECT;
                    end
                end else if (state_reg == S_COLLECT) begin
                    if (tmo_reg == TMO_LAST) begin
                        err_next   = ERR_TMO;
                        cnt_next   = '0;
                        state_next = S_ZEROIZE;
                    end else begin
                        tmo_next = tmo_reg + TMO_W'(1);
                    end
                end
            end
            S_PRESENT: begin
                cnt_next   = '0;
                state_next = S_ZEROIZE;
            end
            S_ZEROIZE: begin
                clr_en = 1'b1;
                if (cnt_reg == LAST_IDX) begin
                    cnt_next   = '0;
                    tmo_next   = '0;
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        ready_int = !rst && (state_reg == S_IDLE || state_reg == S_COLLECT);
        key_load  = (state_reg == S_PRESENT);
        busy      = (state_reg != S_IDLE);
        key_out   = key_load ? key_word : '0;
        err_code  = err_reg;
    end

    assign kw.word_ready = ready_int;

    // One register per key word; word 0 lands in the key MSBs.
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
        logic [WORD_W-1:0] word_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                word_reg <= '0;
            end else if (cnt_reg == CNT_W'(gi)) begin
                if (wr_en)
                    word_reg <= kw.word_data;
                else if (clr_en)
                    word_reg <= '0;
            end
        end

        assign key_word[KEY_W-1-gi*WORD_W -: WORD_W] = word_reg;
    end
endmodule

// File: tb/tb_key_word_assembler.sv
// Self-checking bench for key_word_assembler: directed scenarios plus randomized traffic vs. a queue-based model.
module tb_key_word_assembler;
    localparam int WORD_W      = 32;
    localparam int NUM_WORDS   = 4;
    localparam int TIMEOUT_CYC = 64;
    localparam int KEY_W       = WORD_W * NUM_WORDS;

    logic             clk = 1'b0;
    logic             rst;
    logic             abort;
    logic [KEY_W-1:0] key_out;
    logic             key_load;
    logic             busy;
    logic [2:0]       err_code;

    key_word_if #(.WORD_W(WORD_W)) kw_if ();

    key_word_assembler #(
        .WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .kw(kw_if), .abort(abort),
        .key_out(key_out), .key_load(key_load), .busy(busy), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [KEY_W-1:0] act, input logic [KEY_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: words collected so far, idle run length, pending pulse and wipe countdown.
    logic [WORD_W-1:0] m_words[$];
    int                m_idle    = 0;
    int                m_zero    = 0;
    bit                m_present = 0;
    logic [KEY_W-1:0]  m_key     = '0;
    logic [2:0]        m_err     = 3'd0;
    bit                corrupt_par = 0;

    task automatic m_discard(input logic [2:0] code);
        m_err = code;
        m_words.delete();
        m_idle = 0;
        m_zero = NUM_WORDS;
        $display("key discarded err=%0d at %0t", code, $time);
    endtask

    task automatic model_step();
        if (rst) begin
            m_words.delete();
            m_idle = 0; m_zero = 0; m_present = 0; m_err = 3'd0;
            return;
        end
        if (m_present) begin
            m_present = 0;
            m_zero = NUM_WORDS;
            return;
        end
        if (m_zero > 0) begin
            m_zero--;
            return;
        end
        if (m_words.size() > 0 && abort) begin
            m_discard(3'd3);
            return;
        end
        if (kw_if.word_valid) begin
            if (m_words.size() == 0)
                m_err = 3'd0;
            m_idle = 0;
`ifdef KEY_PARITY_EN
            if ((^kw_if.word_data) != kw_if.word_parity) begin
                m_discard(3'd4);
                return;
            end
`endif
            m_words.push_back(kw_if.word_data);
            if (m_words.size() == NUM_WORDS && kw_if.word_last) begin
                for (int i = 0; i < NUM_WORDS; i++)
                    m_key[KEY_W-1-i*WORD_W -: WORD_W] = m_words[i];
                m_present = 1;
                m_words.delete();
                $display("key loaded %h at %0t", m_key, $time);
            end else if (kw_if.word_last || m_words.size() == NUM_WORDS) begin
                m_discard(3'd1);
            end
        end else if (m_words.size() > 0) begin
            m_idle++;
            if (m_idle == TIMEOUT_CYC)
                m_discard(3'd2);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Every-cycle comparison against the model, on the falling edge.
    initial forever begin
        @(negedge clk);
        check("word_ready", kw_if.word_ready, !rst && !m_present && m_zero == 0);
        check("busy", busy, m_present || m_zero > 0 || m_words.size() > 0);
        check("key_load", key_load, m_present);
        check("key_out", key_out, m_present ? m_key : '0);
        check("err_code", err_code, m_err);
    end

    task automatic drive(input bit v, input logic [WORD_W-1:0] d, input bit l, input bit a);
        kw_if.word_valid = v;
        kw_if.word_data  = d;
        kw_if.word_last  = l;
`ifdef KEY_PARITY_EN
        kw_if.word_parity = (^d) ^ corrupt_par;
`endif
        abort = a;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    logic [WORD_W-1:0] w[NUM_WORDS];

    task automatic send_key();
        for (int i = 0; i < NUM_WORDS; i++)
            drive(1'b1, w[i], i == NUM_WORDS - 1, 1'b0);
    endtask

    localparam logic [KEY_W-1:0] KEY_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [KEY_W-1:0] KEY_B = 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98;

    task automatic set_key(input logic [KEY_W-1:0] k);
        for (int i = 0; i < NUM_WORDS; i++)
            w[i] = k[KEY_W-1-i*WORD_W -: WORD_W];
    endtask

    initial begin
        rst = 1'b1;
        abort = 1'b0;
        kw_if.word_valid = 1'b0;
        kw_if.word_data  = '0;
        kw_if.word_last  = 1'b0;
`ifdef KEY_PARITY_EN
        kw_if.word_parity = 1'b0;
`endif
        idle(2);
        check("rst busy", busy, 1'b0);
        check("rst ready", kw_if.word_ready, 1'b0);
        check("rst key_out", key_out, '0);
        rst = 1'b0;
        idle(1);

        // Nominal key: pulse on the cycle after the last handshake, busy drops 5 cycles later.
        set_key(KEY_A);
        send_key();
        check("t1 key_load", key_load, 1'b1);
        check("t1 key_out", key_out, KEY_A);
        idle(1);
        check("t1 load after", key_load, 1'b0);
        check("t1 key_out after", key_out, '0);
        idle(3);
        check("t1 busy p+4", busy, 1'b1);
        idle(1);
        check("t1 busy p+5", busy, 1'b0);

        // Early word_last.
        drive(1'b1, w[0], 1'b0, 1'b0);
        drive(1'b1, w[1], 1'b1, 1'b0);
        check("t2 err", err_code, 3'd1);
        check("t2 load", key_load, 1'b0);
        idle(4);
        check("t2 err hold", err_code, 3'd1);
        check("t2 idle", busy, 1'b0);
        drive(1'b1, w[0], 1'b0, 1'b0);
        check("t2 err clear", err_code, 3'd0);
        for (int i = 1; i < NUM_WORDS; i++)
            drive(1'b1, w[i], i == NUM_WORDS - 1, 1'b0);
        check("t2 key_out", key_out, KEY_A);
        idle(5);

        // Inter-word timeout.
        drive(1'b1, w[0], 1'b0, 1'b0);
        drive(1'b1, w[1], 1'b0, 1'b0);
        idle(TIMEOUT_CYC - 1);
        check("t3 err pre", err_code, 3'd0);
        idle(1);
        check("t3 err", err_code, 3'd2);
        check("t3 ready z1", kw_if.word_ready, 1'b0);
        idle(3);
        check("t3 ready z4", kw_if.word_ready, 1'b0);
        idle(1);
        check("t3 ready idle", kw_if.word_ready, 1'b1);

        // Abort coinciding with the 3rd handshake.
        drive(1'b1, w[0], 1'b0, 1'b0);
        drive(1'b1, w[1], 1'b0, 1'b0);
        drive(1'b1, w[2], 1'b0, 1'b1);
        check("t4 err", err_code, 3'd3);
        check("t4 load", key_load, 1'b0);
        idle(4);
        set_key(KEY_B);
        send_key();
        check("t4 key_out", key_out, KEY_B);
        idle(5);

        // Reset mid-key.
        set_key(KEY_A);
        for (int i = 0; i < 3; i++)
            drive(1'b1, w[i], 1'b0, 1'b0);
        rst = 1'b1;
        idle(1);
        check("t5 busy", busy, 1'b0);
        check("t5 ready", kw_if.word_ready, 1'b0);
        check("t5 err", err_code, 3'd0);
        rst = 1'b0;
        set_key(KEY_B);
        send_key();
        check("t5 key_out", key_out, KEY_B);
        idle(5);

        // Bad parity on the 2nd word.
        set_key(KEY_A);
        drive(1'b1, w[0], 1'b0, 1'b0);
        corrupt_par = 1;
        drive(1'b1, w[1], 1'b0, 1'b0);
        corrupt_par = 0;
        drive(1'b1, w[2], 1'b0, 1'b0);
        drive(1'b1, w[3], 1'b1, 1'b0);
`ifdef KEY_PARITY_EN
        check("t6 load", key_load, 1'b0);
        check("t6 err", err_code, 3'd4);
`else
        check("t6 load", key_load, 1'b1);
        check("t6 key_out", key_out, KEY_A);
`endif
        idle(6);

        // Randomized traffic; word_last is biased toward the final slot so many keys complete.
        for (int c = 0; c < 3000; c++) begin
            bit v, l, a;
            v = ($urandom % 4) != 0;
            l = (m_words.size() == NUM_WORDS - 1) ? (($urandom % 6) != 0) : (($urandom % 15) == 0);
            a = ($urandom % 50) == 0;
            rst = ($urandom % 400) == 0;
`ifdef KEY_PARITY_EN
            corrupt_par = ($urandom % 40) == 0;
`endif
            if (($urandom % 300) == 0)
                idle(TIMEOUT_CYC + 4);
            else
                drive(v, WORD_W'($urandom), l, a);
        end
        rst = 1'b0;
        corrupt_par = 0;
        idle(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
